upb_ctl: RTL and testbench

UPB_CTL -- requirements
Module: upb_ctl

---
 rtl/upb_ctl.sv | 97 +++++++++
 tb/tb_upb_ctl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/upb_ctl.sv
// upb_ctl: sequences one UPB predictor coefficient update per sample over B1..B6
// and keeps the coefficient and DQ history storage.
module upb_ctl #(
    parameter int LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scan_in0,
    input  logic        scan_in1,
    input  logic        scan_in2,
    input  logic        scan_in3,
    input  logic        scan_in4,
    input  logic        scan_enable,
    input  logic        test_mode,
    output logic        scan_out0,
    output logic        scan_out1,
    output logic        scan_out2,
    output logic        scan_out3,
    output logic        scan_out4,
    input  logic        start,
    input  logic [15:0] DQ,
    input  logic        tr,
    input  logic [1:0]  rate_in,
    output logic        upb_Un,
    output logic [15:0] upb_DQn,
    output logic [15:0] upb_Bn,
    output logic [1:0]  upb_rate,
    input  logic [15:0] upb_BnP,
    output logic        busy,
    output logic        done,
    input  logic [2:0]  rd_sel,
    output logic [15:0] rd_data
);
    typedef enum logic [1:0] {IDLE, ISSUE, SHIFT, DONE} state_t;
    localparam logic [1:0] LAST_CNT = 2'(LAT);
    state_t      state, state_nx;
    logic [2:0]  k;
    logic [1:0]  cnt;
    logic [15:0] b   [6];
    logic [15:0] dqh [6];
    logic [15:0] dq_lat;
    logic        tr_lat;
    logic [1:0]  rate_lat;
    logic        issue, last;
    logic        unused_scan;
    assign unused_scan = ^{scan_in0, scan_in1, scan_in2, scan_in3, scan_in4, scan_enable, test_mode};
    assign {scan_out0, scan_out1, scan_out2, scan_out3, scan_out4} = 5'b0;
    assign issue = state == ISSUE;
    assign last  = issue && cnt == LAST_CNT;
    always_comb begin
        state_nx = state == IDLE  ? (start ? ISSUE : IDLE) :
                   state == ISSUE ? ((last && k == 3'd5) ? SHIFT : ISSUE) :
                   state == SHIFT ? DONE : IDLE;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            k        <= '0;
            cnt      <= '0;
            dq_lat   <= '0;
            tr_lat   <= 1'b0;
            rate_lat <= '0;
            for (int i = 0; i < 6; i++) begin
                b[i]   <= '0;
                dqh[i] <= '0;
            end
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                dq_lat   <= DQ;
                tr_lat   <= tr;
                rate_lat <= rate_in;
                k        <= '0;
                cnt      <= '0;
            end
            if (issue) begin
                cnt <= last ? 2'd0 : cnt + 2'd1;
                if (last) begin
                    b[k] <= tr_lat ? 16'h0000 : upb_BnP;
                    k    <= k == 3'd5 ? 3'd0 : k + 3'd1;
                end
            end
            if (state == SHIFT) begin
                dqh[0] <= dq_lat;
                for (int i = 1; i < 6; i++) dqh[i] <= dqh[i-1];
            end
        end
    end
    // UPB sees live values only while a coefficient is being issued
    assign upb_Un   = issue & (dq_lat[15] ^ dqh[k][15]);
    assign upb_DQn  = issue ? dq_lat : 16'h0000;
    assign upb_Bn   = issue ? b[k] : 16'h0000;
    assign upb_rate = issue ? rate_lat : 2'b00;
    assign busy     = state != IDLE;
    assign done     = state == DONE;
    assign rd_data  = rd_sel < 3'd6 ? b[rd_sel] : 16'h0000;
endmodule

// File: tb/tb_upb_ctl.sv
// tb_upb_ctl: scoreboard bench for upb_ctl with a cycle-driven mock UPB.
module tb_upb_ctl;
    localparam int LAT = 1;
    logic        clk = 0, reset = 0;
    logic        start = 0, tr = 0;
    logic [15:0] DQ = 0, upb_BnP = 0;
    logic [1:0]  rate_in = 0;
    logic [2:0]  rd_sel = 0;
    logic        upb_Un, busy, done;
    logic [15:0] upb_DQn, upb_Bn, rd_data;
    logic [1:0]  upb_rate;
    logic        so0, so1, so2, so3, so4;
    int          tests = 0, fails = 0;
    typedef struct {logic un; logic [15:0] bn; logic [1:0] rate; logic [15:0] dqn;} exp_t;
    exp_t        q[$];
    logic [15:0] mb [6];
    logic [15:0] mdqh [6];

    upb_ctl #(.LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .scan_in0(1'b0), .scan_in1(1'b0), .scan_in2(1'b0), .scan_in3(1'b0), .scan_in4(1'b0),
        .scan_enable(1'b0), .test_mode(1'b0),
        .scan_out0(so0), .scan_out1(so1), .scan_out2(so2), .scan_out3(so3), .scan_out4(so4),
        .start(start), .DQ(DQ), .tr(tr), .rate_in(rate_in),
        .upb_Un(upb_Un), .upb_DQn(upb_DQn), .upb_Bn(upb_Bn), .upb_rate(upb_rate),
        .upb_BnP(upb_BnP), .busy(busy), .done(done), .rd_sel(rd_sel), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic check_reads(input string tag);
        logic [15:0] e;
        for (int s = 0; s < 8; s++) begin
            rd_sel = 3'(s);
            #1;
            e = s < 6 ? mb[s] : 16'h0000;
            tests++;
            if (rd_data !== e) begin
                fails++;
                $display("FAIL %s rd_sel=%0d got %h expected %h", tag, s, rd_data, e);
            end
        end
    endtask

    task automatic run_seq(input logic [15:0] dq, input logic t, input logic [1:0] rate,
                           input logic [15:0] base, input logic inc, input int glitch);
        exp_t e;
        int   cyc;
        @(negedge clk);
        start = 1; DQ = dq; tr = t; rate_in = rate;
        for (int k = 0; k < 6; k++) begin
            e.un = dq[15] ^ mdqh[k][15]; e.bn = mb[k]; e.rate = rate; e.dqn = dq;
            q.push_back(e);
        end
        @(posedge clk); #1;
        start = 0; DQ = ~dq; tr = ~t; rate_in = ~rate;
        for (int k = 0; k < 6; k++) begin
            for (int c = 0; c <= LAT; c++) begin
                @(negedge clk);
                cyc = k * (LAT + 1) + c;
                upb_BnP = c == LAT ? (inc ? base + 16'(k + 1) : base) : 16'hDEAD;
                start = cyc == glitch;
                tests++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    fails++;
                    $display("FAIL issue_status cyc=%0d got busy=%b done=%b expected busy=1 done=0", cyc, busy, done);
                end
                if (c == 0) begin
                    e = q.pop_front();
                    tests++;
                    if (upb_Un !== e.un || upb_Bn !== e.bn || upb_rate !== e.rate || upb_DQn !== e.dqn) begin
                        fails++;
                        $display("FAIL upb_k%0d got Un=%b Bn=%h rate=%0d DQn=%h expected Un=%b Bn=%h rate=%0d DQn=%h",
                                 k + 1, upb_Un, upb_Bn, upb_rate, upb_DQn, e.un, e.bn, e.rate, e.dqn);
                    end
                end
            end
        end
        @(negedge clk);
        start = 0;
        tests++;
        if (busy !== 1'b1 || done !== 1'b0 || upb_Un !== 1'b0 || upb_DQn !== 16'h0 || upb_Bn !== 16'h0 || upb_rate !== 2'b0) begin
            fails++;
            $display("FAIL shift_cycle got busy=%b done=%b Un=%b DQn=%h Bn=%h expected 1 0 0 0 0", busy, done, upb_Un, upb_DQn, upb_Bn);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b1 || busy !== 1'b1 || upb_DQn !== 16'h0) begin
            fails++;
            $display("FAIL done_pulse got done=%b busy=%b DQn=%h expected done=1 busy=1 DQn=0", done, busy, upb_DQn);
        end
        for (int k = 0; k < 6; k++) mb[k] = t ? 16'h0000 : (inc ? base + 16'(k + 1) : base);
        for (int k = 5; k > 0; k--) mdqh[k] = mdqh[k-1];
        mdqh[0] = dq;
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL after_done got done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_reset;
        for (int k = 0; k < 6; k++) begin mb[k] = 0; mdqh[k] = 0; end
        #1;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || upb_Un !== 1'b0 || upb_Bn !== 16'h0 || {so0, so1, so2, so3, so4} !== 5'b0) begin
            fails++;
            $display("FAIL reset_outputs got busy=%b done=%b Un=%b Bn=%h expected all 0", busy, done, upb_Un, upb_Bn);
        end
        repeat (2) @(negedge clk);
        reset = 1;
        @(negedge clk);
        check_reads("reset_read");
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_release got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_first_sample;
        run_seq(16'h8005, 1'b0, 2'd2, 16'h0100, 1'b1, -1);
        check_reads("first_read");
    endtask

    task automatic test_second_sample;
        run_seq(16'h0003, 1'b0, 2'd1, 16'h0200, 1'b1, -1);
        check_reads("second_read");
    endtask

    task automatic test_back_to_back;
        run_seq(16'h8011, 1'b0, 2'd3, 16'h0300, 1'b1, 3);
        run_seq(16'h8000, 1'b0, 2'd0, 16'h0400, 1'b1, -1);
        check_reads("b2b_read");
    endtask

    task automatic test_tr;
        run_seq(16'h0777, 1'b1, 2'd2, 16'h7FFF, 1'b0, -1);
        check_reads("tr_read");
        run_seq(16'h8888, 1'b0, 2'd1, 16'h0500, 1'b1, -1);
        check_reads("post_tr_read");
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        start = 1; DQ = 16'h8123; tr = 0; rate_in = 2'd1;
        @(posedge clk); #1;
        start = 0;
        for (int n = 0; n < 2 * (LAT + 1); n++) begin
            @(negedge clk);
            upb_BnP = 16'h5555;
        end
        @(negedge clk);
        reset = 0;
        #1;
        for (int k = 0; k < 6; k++) begin mb[k] = 0; mdqh[k] = 0; end
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || upb_Un !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_status got busy=%b done=%b Un=%b expected 0 0 0", busy, done, upb_Un);
        end
        check_reads("reset_mid_read");
        repeat (2) @(negedge clk);
        reset = 1;
        for (int n = 0; n < 14; n++) begin
            @(negedge clk);
            tests++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL reset_mid_nodone cyc=%0d got done=%b busy=%b expected 0 0", n, done, busy);
            end
        end
        run_seq(16'h8001, 1'b0, 2'd3, 16'h0600, 1'b1, -1);
        check_reads("reset_mid_rerun");
    endtask

    initial begin
        test_reset;
        test_first_sample;
        test_second_sample;
        test_back_to_back;
        test_tr;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
